// File: rtl/cpu_axi_pkg.sv
// +---------------------------------------------------------------------+
// | cpu_axi_pkg : shared FSM encodings and AXI constants for line reader |
// | Revision    : 1.0                                                    |
// +---------------------------------------------------------------------+
`default_nettype none

package cpu_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AR2  = 3'd3,
    ST_R2   = 3'd4,
    ST_RET  = 3'd5
  } rd_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [7:0] LEN_LINE       = 8'd7;
  localparam logic [7:0] LEN_HALF       = 8'd3;
  localparam logic [7:0] LEN_WORD       = 8'd0;

  // An 8-beat burst from the last 16-byte slot of a page would cross 4KB.
  function automatic logic crosses_4k(input logic [31:0] addr);
    return addr[11:4] == 8'hFF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rd_line_buffer.sv
// +---------------------------------------------------------------------+
// | rd_line_buffer : 256-bit return register with beat counter placement |
// | Revision       : 1.0                                                 |
// +---------------------------------------------------------------------+
`default_nettype none

module rd_line_buffer (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic         beat_en,
  input  logic [31:0]  beat_data,
  output logic [2:0]   beat_idx,
  output logic [255:0] line_data
);

  logic [2:0]   cnt_q, cnt_d;
  logic [255:0] data_q, data_d;

  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    if (clear) begin
      cnt_d  = 3'd0;
      data_d = '0;
    end else if (beat_en) begin
      data_d[{cnt_q, 5'b00000} +: 32] = beat_data;
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= 3'd0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  assign beat_idx  = cnt_q;
  assign line_data = data_q;

endmodule

`default_nettype wire

// File: rtl/axi_line_reader.sv
// +---------------------------------------------------------------------+
// | axi_line_reader : AXI read master for cache lines / uncached words   |
// | Optional: LINE_READER_CHECK_EN enables R-channel error checking      |
// | Revision        : 1.0                                                |
// +---------------------------------------------------------------------+
`default_nettype none

module axi_line_reader
  import cpu_axi_pkg::*;
#(
  parameter logic [3:0] ARID_VAL = 4'd0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic         rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [255:0] ret_data,
  output logic         rd_err,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  rd_state_e   state_q, state_d;
  logic        type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic        accept, beat, split;
  logic [31:0] line_base;
  logic [2:0]  beat_idx;

  assign accept    = rd_req && rd_rdy;
  assign beat      = rvalid && rready;
  assign split     = type_q && crosses_4k(addr_q);
  assign line_base = {addr_q[31:4], 4'h0};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      type_q  <= 1'b0;
      addr_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    type_d  = accept ? rd_type : type_q;
    addr_d  = accept ? rd_addr : addr_q;
    case (state_q)
      ST_IDLE: if (rd_req)           state_d = ST_AR;
      ST_AR:   if (arready)          state_d = ST_R;
      ST_R:    if (rvalid && rlast)  state_d = split ? ST_AR2 : ST_RET;
      ST_AR2:  if (arready)          state_d = ST_R2;
      ST_R2:   if (rvalid && rlast)  state_d = ST_RET;
      ST_RET:                        state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_rdy    = (state_q == ST_IDLE);
    arvalid   = (state_q == ST_AR) || (state_q == ST_AR2);
    rready    = (state_q == ST_R)  || (state_q == ST_R2);
    ret_valid = (state_q == ST_RET);
    araddr    = addr_q;
    arlen     = LEN_WORD;
    if (state_q == ST_AR2) begin
      araddr = line_base + 32'd16;
      arlen  = LEN_HALF;
    end else if (type_q) begin
      araddr = line_base;
      arlen  = split ? LEN_HALF : LEN_LINE;
    end
  end

  assign arid    = ARID_VAL;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;

  rd_line_buffer u_buf (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (accept),
    .beat_en   (beat),
    .beat_data (rdata),
    .beat_idx  (beat_idx),
    .line_data (ret_data)
  );

`ifdef LINE_READER_CHECK_EN
  logic       err_q, err_d;
  logic [2:0] final_k;
  logic       bad_beat;

  // Split first half ends at k=3; uncached at k=0; everything else at k=7.
  always_comb begin
    if (!type_q)                      final_k = 3'd0;
    else if (state_q == ST_R && split) final_k = 3'd3;
    else                              final_k = 3'd7;
    bad_beat = (rresp != 2'b00) || (rid != ARID_VAL) || (rlast != (beat_idx == final_k));
    err_d    = err_q;
    if (accept)                err_d = 1'b0;
    else if (beat && bad_beat) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign rd_err = err_q && (state_q == ST_RET);
`else
  logic unused_chk;
  assign unused_chk = ^{rid, rresp, beat_idx};
  assign rd_err     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_line_reader.sv
// +---------------------------------------------------------------------+
// | tb_axi_line_reader : directed vector bench for axi_line_reader       |
// | Revision           : 1.0                                             |
// +---------------------------------------------------------------------+
`default_nettype none

module tb_axi_line_reader;

  logic         clk = 1'b0;
  logic         resetn;
  logic         rd_req, rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy, ret_valid, rd_err;
  logic [255:0] ret_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  axi_line_reader #(.ARID_VAL(4'd0)) dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
    .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_data(ret_data), .rd_err(rd_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic             typ;
    logic [31:0]      addr;
    logic [7:0][31:0] data;
    logic [31:0]      exp_addr0;
    logic [31:0]      exp_addr1;
    logic [7:0]       exp_len;
    logic             split;
    int               ar_wait;
    logic             toggle;
    int               err_beat;
    logic             chk_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic typ, input logic [31:0] addr,
                              input logic [31:0] base, input logic [31:0] step,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [7:0] len, input logic split,
                              input int ar_wait, input logic toggle,
                              input int err_beat, input logic chk_lat);
    vec_t v;
    v.typ = typ; v.addr = addr;
    for (int i = 0; i < 8; i++) v.data[i] = base + step * i;
    v.exp_addr0 = a0; v.exp_addr1 = a1; v.exp_len = len; v.split = split;
    v.ar_wait = ar_wait; v.toggle = toggle; v.err_beat = err_beat; v.chk_lat = chk_lat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int t_acc, nbursts, nbeats, k, w;
    logic [255:0] exp_data;
    logic [31:0] ea;
    logic exp_err;
    @(negedge clk);
    rd_req = 1'b1; rd_type = v.typ; rd_addr = v.addr;
    chk($sformatf("v%0d_rd_rdy", id), rd_rdy, 1);
    t_acc = cyc;
    @(negedge clk);
    rd_req = 1'b0; rd_type = 1'b0; rd_addr = 32'h0;
    nbursts = v.split ? 2 : 1;
    nbeats  = v.typ ? (v.split ? 4 : 8) : 1;
    k = 0;
    for (int b = 0; b < nbursts; b++) begin
      w = 0;
      while (!arvalid && w < 20) begin @(negedge clk); w++; end
      ea = (b == 0) ? v.exp_addr0 : v.exp_addr1;
      chk($sformatf("v%0d_ar%0d", id, b), {arvalid, arid, araddr, arlen, arsize, arburst},
          {1'b1, 4'd0, ea, v.exp_len, 3'd2, 2'b01});
      for (int i = 0; i < v.ar_wait; i++) begin
        @(negedge clk);
        chk($sformatf("v%0d_ar_hold", id), {arvalid, araddr, arlen}, {1'b1, ea, v.exp_len});
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
        if (v.toggle) begin
          rvalid = 1'b0; rdata = 32'hBAD0_0000 | i; rlast = 1'b1;
          @(negedge clk);
          rlast = 1'b0;
        end
        chk($sformatf("v%0d_rready", id), rready, 1);
        rvalid = 1'b1; rdata = v.data[k]; rlast = (i == nbeats - 1);
        rresp  = (k == v.err_beat) ? 2'b10 : 2'b00;
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = 32'h0;
        k++;
      end
    end
    w = 0;
    while (!ret_valid && w < 20) begin @(negedge clk); w++; end
    chk($sformatf("v%0d_ret_valid", id), ret_valid, 1);
    if (v.chk_lat) chk($sformatf("v%0d_latency", id), cyc - t_acc, 10);
    exp_data = v.typ ? v.data : {224'd0, v.data[0]};
`ifdef LINE_READER_CHECK_EN
    exp_err = (v.err_beat >= 0);
`else
    exp_err = 1'b0;
`endif
    chk($sformatf("v%0d_ret_data", id), ret_data, exp_data);
    chk($sformatf("v%0d_rd_err", id), {rd_err, rready, arvalid}, {exp_err, 2'b00});
    @(negedge clk);
    chk($sformatf("v%0d_after_ret", id), {ret_valid, rd_err, rd_rdy}, 3'b001);
    chk($sformatf("v%0d_data_held", id), ret_data, exp_data);
  endtask

  initial begin
    logic seen;
    resetn = 1'b0; rd_req = 1'b0; rd_type = 1'b0; rd_addr = 32'h0;
    arready = 1'b0; rid = 4'd0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

    vecs[0] = mk(1'b1, 32'h1FC0_0010, 32'h11, 32'h11, 32'h1FC0_0010, 32'h0, 8'd7, 1'b0, 0, 1'b0, -1, 1'b1);
    vecs[1] = mk(1'b0, 32'hBFAF_8004, 32'hDEAD_BEEF, 32'h0, 32'hBFAF_8004, 32'h0, 8'd0, 1'b0, 0, 1'b0, -1, 1'b0);
    vecs[2] = mk(1'b1, 32'h0000_0FF0, 32'hA0, 32'h1, 32'h0000_0FF0, 32'h0000_1000, 8'd3, 1'b1, 0, 1'b0, -1, 1'b0);
    vecs[3] = mk(1'b1, 32'h0000_1234, 32'h0101_0101, 32'h0101_0101, 32'h0000_1230, 32'h0, 8'd7, 1'b0, 5, 1'b1, -1, 1'b0);
    vecs[4] = mk(1'b0, 32'h0000_0FF0, 32'h1234_5678, 32'h0, 32'h0000_0FF0, 32'h0, 8'd0, 1'b0, 1, 1'b1, -1, 1'b0);
    vecs[5] = mk(1'b1, 32'hFFFF_FFF8, 32'hC000_0000, 32'h10, 32'hFFFF_FFF0, 32'h0000_0000, 8'd3, 1'b1, 2, 1'b1, -1, 1'b0);
    vecs[6] = mk(1'b1, 32'h2000_0040, 32'h5500_0000, 32'h3, 32'h2000_0040, 32'h0, 8'd7, 1'b0, 0, 1'b0, 5, 1'b0);
    vecs[7] = mk(1'b1, 32'h2000_0060, 32'h6600_0000, 32'h7, 32'h2000_0060, 32'h0, 8'd7, 1'b0, 0, 1'b0, -1, 1'b0);

    repeat (2) @(negedge clk);
    chk("reset_state", {rd_rdy, arvalid, rready, ret_valid, rd_err, ret_data}, {5'b10000, 256'd0});
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset in the middle of a line burst, after three beats.
    @(negedge clk);
    rd_req = 1'b1; rd_type = 1'b1; rd_addr = 32'h3000_0000;
    @(negedge clk);
    rd_req = 1'b0; arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'b1; rdata = 32'h7700_0000 + i;
      @(negedge clk);
    end
    rdata = 32'h7700_0003;
    #2 resetn = 1'b0;
    #1 chk("rst_mid_outputs", {arvalid, rready, ret_valid, rd_err, ret_data}, {4'b0000, 256'd0});
    rvalid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ret_valid || arvalid || rready) seen = 1'b1;
    end
    chk("rst_no_ret", {seen, rd_rdy}, 2'b01);

    run_vec(vecs[0], 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
